spectrum_peak_detector: RTL and testbench
=========================================

Name: spectrum_peak_detector

Overview:
Sits directly downstream of the FFT magnitude stage and consumes its stream of 32-bit squared-magnitude bins, one half-spectrum (N_BINS bins) per frame. Per frame it tracks the maximum bin, that bin's index, and the total spectral energy. At frame end it compares the peak against a programmable threshold and raises a per-frame defect verdict for the tile-classification logic. Inputs are registered; there are no combinational input-to-output paths.

Parameters:
N_BINS, 2048, bins per frame (half of a 4096-point FFT); must be a power of 2, >= 4
AMP_W, 32, width of incoming amplitude
IDX_W, 11, bin index width, = log2(N_BINS)
ENG_W, 43, energy accumulator width, = AMP_W + IDX_W (cannot overflow)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  one-cycle pulse, same pulse that starts the FFT; arms a new frame
amp_i  in  AMP_W  bin amplitude (unsigned)
amp_valid_i  in  1  amp_i valid this cycle; gaps between valid cycles allowed
thresh_i  in  AMP_W  defect threshold (unsigned); quasi-static
peak_amp_o  out  AMP_W  largest amplitude of last completed frame
peak_idx_o  out  IDX_W  bin index of peak_amp_o
energy_o  out  ENG_W  sum of all amplitudes of last completed frame
defect_o  out  1  peak_amp_o >= thresh_i, sampled at frame end
result_valid_o  out  1  one-cycle pulse: outputs above updated
busy_o  out  1  high while not IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal bin_cnt, run_max, run_idx, run_eng = 0.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE: amp_valid_i ignored. On start_i -> COLLECT; clear bin_cnt, run_max, run_idx, run_eng on that edge.
- COLLECT, each edge with amp_valid_i=1:
  - run_eng += amp_i.
  - If amp_i > run_max (strictly greater): run_max=amp_i, run_idx=bin_cnt. Ties keep the earliest bin. A frame of all zeros reports idx 0.
  - bin_cnt += 1. If bin_cnt == N_BINS-1 on this edge, next state = REPORT. The sample itself is included.
- COLLECT with amp_valid_i=0: hold all state. There is no timeout.
- REPORT (exactly one cycle):
  - On the exit edge, register peak_amp_o=run_max, peak_idx_o=run_idx, energy_o=run_eng, defect_o=(run_max >= thresh_i).
  - result_valid_o=1 for the following cycle only; state -> IDLE.
- Latency: result_valid_o is high in the 2nd cycle after the edge that accepts the last bin.
- Result outputs hold their values until the next REPORT or reset. A start_i that aborts a frame does not alter them.
- start_i in COLLECT restarts the frame: counters and accumulators are cleared and the state stays COLLECT. If amp_valid_i is coincident with that start_i, it is dropped (start has priority).
- start_i in REPORT: the report completes normally and the FSM enters COLLECT with cleared accumulators. The pulse is not lost.
- amp_valid_i in REPORT is dropped.
- busy_o = (state != IDLE), registered from the state.
- All comparisons are unsigned. Energy is zero-extended before the add.

Decomposition:
- Shared package fft_post_pkg:
  - FSM state encoding (IDLE=0, COLLECT=1, REPORT=2, 2 bits).
  - Constants FFT_POINTS=4096, N_BINS=FFT_POINTS/2, AMP_W=32, IDX_W, ENG_W.
  - A clog2 function.
- No sub-module: max-tracking and accumulation are small enough to live in a single module.

Test Plan:
- N_BINS=8, start then amps 1,5,3,9,2,9,0,4 back-to-back, thresh=9 -> peak_amp=9, peak_idx=3 (tie keeps first), energy=33, defect=1, result_valid single pulse 2 cycles after the last sample.
- Same frame with thresh=10 -> defect=0. Same frame with amp_valid gaps of 0-3 cycles between samples -> identical results, busy_o high throughout.
- Frame of all zeros -> peak_amp=0, peak_idx=0, energy=0. Also amp_i=FFFFFFFF on all 8 bins -> energy=7_FFFF_FFF8 (no overflow).
- 4 valid samples, then start_i, then a full frame 2,2,2,2,2,2,2,7 -> first partial frame discarded, peak_idx=7, energy=21, exactly one result_valid.
- rst_i asserted mid-COLLECT, asynchronous to the edge -> all outputs 0 immediately, busy_o=0. Valid samples without a start are ignored, with no result_valid.
- start_i coincident with the REPORT cycle -> result of the old frame is reported and the next 8 samples form a new frame. amp_valid_i in IDLE -> no state change.

Source files
------------

// File: rtl/fft_post_pkg.sv
// Shared definitions for the FFT post-processing blocks.
// Holds the FFT geometry constants, derived widths, the peak-detector
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package fft_post_pkg;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int FFT_POINTS = 4096;
  localparam int N_BINS     = FFT_POINTS / 2;
  localparam int AMP_W      = 32;
  localparam int IDX_W      = clog2(N_BINS);
  localparam int ENG_W      = AMP_W + IDX_W;

  // Peak-detector FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

endpackage

// File: rtl/spectrum_peak_detector.sv
// Per-frame peak / energy tracker for the FFT squared-magnitude stream.
// Latency: result_valid_o pulses in the 2nd cycle after the last bin is accepted.
// Backpressure: none; amp_valid_i may gap freely, every valid bin in COLLECT is taken.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i        arms a new frame (also restarts a frame in progress)
//   amp_i/amp_valid_i  unsigned bin amplitude stream
//   thresh_i       quasi-static defect threshold
//   peak_amp_o, peak_idx_o, energy_o, defect_o  results of last completed frame
//   result_valid_o one-cycle pulse when the results above update
//   busy_o         high whenever the FSM is not IDLE
module spectrum_peak_detector
  import fft_post_pkg::ST_IDLE;
  import fft_post_pkg::ST_COLLECT;
  import fft_post_pkg::ST_REPORT;
#(
  parameter int N_BINS = fft_post_pkg::N_BINS,
  parameter int AMP_W  = fft_post_pkg::AMP_W,
  parameter int IDX_W  = fft_post_pkg::clog2(N_BINS),
  parameter int ENG_W  = AMP_W + IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AMP_W-1:0] amp_i,
  input  logic             amp_valid_i,
  input  logic [AMP_W-1:0] thresh_i,
  output logic [AMP_W-1:0] peak_amp_o,
  output logic [IDX_W-1:0] peak_idx_o,
  output logic [ENG_W-1:0] energy_o,
  output logic             defect_o,
  output logic             result_valid_o,
  output logic             busy_o
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BINS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] bin_cnt;
  logic [AMP_W-1:0] run_max;
  logic [IDX_W-1:0] run_idx;
  logic [ENG_W-1:0] run_eng;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      bin_cnt        <= '0;
      run_max        <= '0;
      run_idx        <= '0;
      run_eng        <= '0;
      peak_amp_o     <= '0;
      peak_idx_o     <= '0;
      energy_o       <= '0;
      defect_o       <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_COLLECT;
            bin_cnt <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_eng <= '0;
          end
        end

        ST_COLLECT: begin
          // A restart wins over a coincident sample; that sample is dropped.
          if (start_i) begin
            bin_cnt <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_eng <= '0;
          end else if (amp_valid_i) begin
            run_eng <= run_eng + ENG_W'(amp_i);
            // Strict compare: ties keep the earliest bin, all-zero frame reports bin 0.
            if (amp_i > run_max) begin
              run_max <= amp_i;
              run_idx <= bin_cnt;
            end
            bin_cnt <= bin_cnt + IDX_W'(1);
            if (bin_cnt == LAST_BIN) begin
              state <= ST_REPORT;
            end
          end
        end

        ST_REPORT: begin
          peak_amp_o     <= run_max;
          peak_idx_o     <= run_idx;
          energy_o       <= run_eng;
          defect_o       <= (run_max >= thresh_i);
          result_valid_o <= 1'b1;
          // A start landing on the report cycle opens the next frame directly;
          // the current results are read above before the clear takes effect.
          if (start_i) begin
            state   <= ST_COLLECT;
            bin_cnt <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_eng <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register, so still free of input paths.
  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_spectrum_peak_detector.sv
module tb_spectrum_peak_detector;

  localparam int NB = 8;
  localparam int AW = 32;
  localparam int IW = 3;
  localparam int EW = 35;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] amp_i;
  logic          amp_valid_i;
  logic [AW-1:0] thresh_i;
  logic [AW-1:0] peak_amp_o;
  logic [IW-1:0] peak_idx_o;
  logic [EW-1:0] energy_o;
  logic          defect_o;
  logic          result_valid_o;
  logic          busy_o;

  spectrum_peak_detector #(
    .N_BINS(NB), .AMP_W(AW), .IDX_W(IW), .ENG_W(EW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .amp_i(amp_i),
    .amp_valid_i(amp_valid_i), .thresh_i(thresh_i),
    .peak_amp_o(peak_amp_o), .peak_idx_o(peak_idx_o), .energy_o(energy_o),
    .defect_o(defect_o), .result_valid_o(result_valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;

  logic [AW-1:0] frame [NB];
  logic [AW-1:0] exp_amp;
  logic [IW-1:0] exp_idx;
  logic [63:0]   exp_eng;
  logic          exp_def;

  always @(negedge clk_i) if (result_valid_o === 1'b1) pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: peak is the first maximal bin, energy the plain sum of the frame.
  task automatic compute_expected();
    exp_amp = '0;
    exp_idx = '0;
    exp_eng = '0;
    for (int i = 0; i < NB; i++) begin
      exp_eng = exp_eng + 64'(frame[i]);
      if (frame[i] > exp_amp) begin
        exp_amp = frame[i];
        exp_idx = IW'(i);
      end
    end
    exp_def = (exp_amp >= thresh_i);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    amp_valid_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Drive the frame; the last sample is followed by no gap so report timing is fixed.
  task automatic send_samples(input int gap_max);
    for (int i = 0; i < NB; i++) begin
      amp_i = frame[i];
      amp_valid_i = 1'b1;
      @(negedge clk_i);
      amp_valid_i = 1'b0;
      if (i != NB - 1) begin
        check("busy_collect", 64'(busy_o), 64'd1);
        repeat ($urandom_range(0, gap_max)) begin
          amp_i = $urandom;
          @(negedge clk_i);
          check("busy_gap", 64'(busy_o), 64'd1);
        end
      end
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_rv"},     64'(result_valid_o), 64'd1);
    check({tag, "_amp"},    64'(peak_amp_o), 64'(exp_amp));
    check({tag, "_idx"},    64'(peak_idx_o), 64'(exp_idx));
    check({tag, "_energy"}, 64'(energy_o), exp_eng);
    check({tag, "_defect"}, 64'(defect_o), 64'(exp_def));
    exp_pulses++;
  endtask

  // Called one negedge after the edge that took the last bin (FSM in REPORT).
  task automatic expect_report(input string tag);
    compute_expected();
    check({tag, "_rv_early"}, 64'(result_valid_o), 64'd0);
    @(negedge clk_i);
    check_results(tag);
    @(negedge clk_i);
    check({tag, "_rv_single"}, 64'(result_valid_o), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_frame(input string tag, input int gap_max);
    do_start();
    send_samples(gap_max);
    expect_report(tag);
  endtask

  task automatic load_frame(input logic [AW-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    frame[0] = a0; frame[1] = a1; frame[2] = a2; frame[3] = a3;
    frame[4] = a4; frame[5] = a5; frame[6] = a6; frame[7] = a7;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    amp_i = '0;
    amp_valid_i = 1'b0;
    thresh_i = 32'd9;
    repeat (2) @(negedge clk_i);
    check("rst_amp", 64'(peak_amp_o), 64'd0);
    check("rst_idx", 64'(peak_idx_o), 64'd0);
    check("rst_energy", 64'(energy_o), 64'd0);
    check("rst_rv", 64'(result_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Samples in IDLE are ignored.
    repeat (5) begin
      amp_i = $urandom;
      amp_valid_i = 1'b1;
      @(negedge clk_i);
      check("idle_busy", 64'(busy_o), 64'd0);
      check("idle_rv", 64'(result_valid_o), 64'd0);
    end
    amp_valid_i = 1'b0;

    load_frame(1, 5, 3, 9, 2, 9, 0, 4);
    thresh_i = 32'd9;
    run_frame("basic", 0);
    check("basic_const_eng", 64'(energy_o), 64'd33);
    check("basic_const_idx", 64'(peak_idx_o), 64'd3);
    thresh_i = 32'd10;
    run_frame("thresh10", 0);
    check("thresh10_def", 64'(defect_o), 64'd0);
    thresh_i = 32'd9;
    run_frame("gaps", 3);

    load_frame(0, 0, 0, 0, 0, 0, 0, 0);
    run_frame("zeros", 1);
    for (int i = 0; i < NB; i++) frame[i] = 32'hFFFF_FFFF;
    run_frame("allones", 0);
    check("allones_const_eng", 64'(energy_o), 64'h7_FFFF_FFF8);

    // Partial frame aborted by a fresh start.
    do_start();
    for (int i = 0; i < 4; i++) begin
      amp_i = 32'd100 + 32'(i);
      amp_valid_i = 1'b1;
      @(negedge clk_i);
    end
    amp_valid_i = 1'b0;
    check("abort_no_rv", 64'(result_valid_o), 64'd0);
    load_frame(2, 2, 2, 2, 2, 2, 2, 7);
    run_frame("abort", 0);
    check("abort_const_idx", 64'(peak_idx_o), 64'd7);
    check("abort_const_eng", 64'(energy_o), 64'd21);

    // Asynchronous reset in the middle of COLLECT.
    do_start();
    for (int i = 0; i < 3; i++) begin
      amp_i = $urandom;
      amp_valid_i = 1'b1;
      @(negedge clk_i);
    end
    amp_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("arst_amp", 64'(peak_amp_o), 64'd0);
    check("arst_idx", 64'(peak_idx_o), 64'd0);
    check("arst_energy", 64'(energy_o), 64'd0);
    check("arst_defect", 64'(defect_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) begin
      amp_i = $urandom;
      amp_valid_i = 1'b1;
      @(negedge clk_i);
      check("nostart_busy", 64'(busy_o), 64'd0);
      check("nostart_rv", 64'(result_valid_o), 64'd0);
    end
    amp_valid_i = 1'b0;

    // Start coincident with the REPORT cycle.
    for (int i = 0; i < NB; i++) frame[i] = $urandom_range(0, 15);
    do_start();
    send_samples(1);
    compute_expected();
    check("coinc_rv_early", 64'(result_valid_o), 64'd0);
    start_i = 1'b1;
    amp_i = $urandom;
    amp_valid_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    amp_valid_i = 1'b0;
    check_results("coinc_old");
    check("coinc_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < NB; i++) frame[i] = $urandom;
    send_samples(2);
    expect_report("coinc_new");

    // Randomised frames: narrow range to provoke ties, full range for wide sums.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NB; i++)
        frame[i] = (f % 2 == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
      thresh_i = (f % 2 == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom);
      run_frame("random", 2);
    end

    repeat (3) @(negedge clk_i);
    #1;
    check("pulse_count", 64'(pulses), 64'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
